sme_dom_rng: RTL and testbench

//  Guard-randomness source for the SME DOM AND gadgets: drives the N*D*(D-1)/2-bit
//  rng bus that each masked AND consumes per enabled operation. Holds a bank of K
//  32-bit Galois LFSRs, loaded through a 32-bit seed handshake, stepped once per

---
 rtl/sme_dom_rng_if.sv | 24 ++
 rtl/sme_dom_rng.sv | 119 +++++++++++
 tb/tb_sme_dom_rng.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_dom_rng_if.sv
// Seed and randomness handshake bundle for the DOM guard-randomness source.
// The master side offers seed words and acknowledges consumed randomness;
// the slave side (the generator) accepts seeds and presents the rng bus.
interface sme_dom_rng_if #(
  parameter int RBITS = 96
);
  logic             seed_valid;
  logic             seed_ready;
  logic [31:0]      seed_data;
  logic             rng_valid;
  logic             rng_ack;
  logic [RBITS-1:0] rng;
  logic             reseed_req;

  modport master (
    output seed_valid, seed_data, rng_ack,
    input  seed_ready, rng_valid, rng, reseed_req
  );

  modport slave (
    input  seed_valid, seed_data, rng_ack,
    output seed_ready, rng_valid, rng, reseed_req
  );
endinterface

// File: rtl/sme_dom_rng.sv
// Guard-randomness source for the SME DOM AND gadgets.
// A bank of K 32-bit Galois LFSRs is loaded one word per seed beat and
// stepped once per consumer acknowledge. Randomness is only exposed while
// the bank is fully seeded and within its reseed interval; otherwise the
// rng bus reads as zero and a reseed is requested. D must be at least 2.
module sme_dom_rng #(
  parameter int          D               = 3,
  parameter int          N               = 32,
  parameter int          RESEED_INTERVAL = 0,
  parameter logic [31:0] POLY            = 32'h80200003
) (
  input logic          g_clk,
  input logic          g_resetn,
  sme_dom_rng_if.slave bus
);

  localparam int RBITS = N * D * (D - 1) / 2;
  localparam int K     = (RBITS + 31) / 32;
  localparam int CW    = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam int IW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    UNSEEDED,
    LOADING,
    RUN,
    EXHAUSTED
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [31:0]      r_lfsr [K];
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_count;

  logic             w_beat;
  logic             w_step;
  logic             w_lastWord;
  logic             w_limitHit;
  logic             w_valid;
  logic [IW-1:0]    w_wordSel;
  logic [CW-1:0]    w_countInc;
  logic [31:0]      w_seedWord;
  logic [K*32-1:0]  w_cat;

  // One Galois shift: feedback taps folded in whenever the bit shifted out is 1.
  function automatic logic [31:0] stepLfsr(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Seed beats always take priority over stepping; a zero seed word is
  // replaced by 1 so no LFSR can ever lock up in the all-zero state.
  always_comb begin
    w_beat     = bus.seed_valid;
    w_step     = (r_state == RUN) && bus.rng_ack && !bus.seed_valid;
    w_wordSel  = (r_state == LOADING) ? r_idx : '0;
    w_lastWord = (w_wordSel == IW'(K - 1));
    w_countInc = r_count + 1'b1;
    w_limitHit = (RESEED_INTERVAL > 0) && (w_countInc == CW'(RESEED_INTERVAL));
    w_seedWord = (bus.seed_data == 32'h0) ? 32'h1 : bus.seed_data;
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= UNSEEDED;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: any beat starts or continues a load; the final word enters RUN;
  // the ack reaching the interval limit retires the seed.
  always_comb begin
    w_stateNext = r_state;
    if (w_beat) begin
      w_stateNext = w_lastWord ? RUN : LOADING;
    end else if (w_step && w_limitHit) begin
      w_stateNext = EXHAUSTED;
    end
  end

  // LFSR bank, load index and ack counter; reset discards any partial seed.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int k = 0; k < K; k++) begin
        r_lfsr[k] <= 32'h0;
      end
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_beat) begin
      r_lfsr[w_wordSel] <= w_seedWord;
      r_idx             <= w_lastWord ? '0 : w_wordSel + 1'b1;
      r_count           <= '0;
    end else if (w_step) begin
      for (int k = 0; k < K; k++) begin
        r_lfsr[k] <= stepLfsr(r_lfsr[k]);
      end
      r_count <= w_countInc;
    end
  end

  // Flatten the bank with LFSR 0 in the least significant word.
  always_comb begin
    w_cat = '0;
    for (int k = 0; k < K; k++) begin
      w_cat[k*32 +: 32] = r_lfsr[k];
    end
  end

  // Outputs follow the state alone; rng is masked to zero outside RUN.
  always_comb begin
    w_valid        = (r_state == RUN);
    bus.seed_ready = 1'b1;
    bus.rng_valid  = w_valid;
    bus.reseed_req = (r_state == UNSEEDED) || (r_state == EXHAUSTED);
    bus.rng        = w_valid ? w_cat[RBITS-1:0] : '0;
  end

endmodule

// File: tb/tb_sme_dom_rng.sv
// Self-checking bench for sme_dom_rng (D=3, N=32, so three seed words).
// Two instances share one stimulus stream: dutA never exhausts, dutB
// retires its seed after four acks. A table of vectors covers the basic
// seeding and stepping cases, hand-written sequences cover exhaustion and
// reset mid-load, and a random phase is scored against a word-level model.
module tb_sme_dom_rng;

  localparam int          KW   = 3;
  localparam logic [31:0] POLY = 32'h80200003;

  logic        g_clk;
  logic        g_resetn;
  logic        seedValid;
  logic [31:0] seedData;
  logic        rngAck;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [31:0] w [KW];
    bit          running;
    bit          loading;
    int          nextWord;
    int          acks;
  } model_t;

  typedef struct {
    bit          sv;
    logic [31:0] sd;
    bit          ack;
    bit          expValid;
    logic [95:0] expRng;
    bit          expReq;
  } vec_t;

  model_t mA;
  model_t mB;
  vec_t   vecs [13];

  sme_dom_rng_if #(.RBITS(96)) busA ();
  sme_dom_rng_if #(.RBITS(96)) busB ();

  assign busA.seed_valid = seedValid;
  assign busA.seed_data  = seedData;
  assign busA.rng_ack    = rngAck;
  assign busB.seed_valid = seedValid;
  assign busB.seed_data  = seedData;
  assign busB.rng_ack    = rngAck;

  sme_dom_rng #(.D(3), .N(32), .RESEED_INTERVAL(0), .POLY(POLY)) dutA (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (busA)
  );

  sme_dom_rng #(.D(3), .N(32), .RESEED_INTERVAL(4), .POLY(POLY)) dutB (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (busB)
  );

  // Free-running 10 ns clock.
  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  // Advance a Galois LFSR word by one step using plain arithmetic.
  function automatic logic [31:0] galoisStep(input logic [31:0] s);
    logic [31:0] half;
    half = s / 2;
    return (s % 2 == 1) ? (half ^ POLY) : half;
  endfunction

  function automatic model_t modelReset();
    model_t n;
    foreach (n.w[k]) n.w[k] = 32'h0;
    n.running  = 1'b0;
    n.loading  = 1'b0;
    n.nextWord = 0;
    n.acks     = 0;
    return n;
  endfunction

  // One clock of the behavioural model: seed beats fill words in order and
  // only a complete set of words makes randomness available again.
  function automatic model_t modelEdge(input model_t m, input bit sv, input logic [31:0] sd,
                                       input bit ack, input int interval);
    model_t n;
    int     slot;
    n = m;
    if (sv) begin
      slot       = n.loading ? n.nextWord : 0;
      n.w[slot]  = (sd == 32'h0) ? 32'h1 : sd;
      n.loading  = 1'b1;
      n.running  = 1'b0;
      n.nextWord = slot + 1;
      if (n.nextWord == KW) begin
        n.loading  = 1'b0;
        n.running  = 1'b1;
        n.nextWord = 0;
        n.acks     = 0;
      end
    end else if (ack && n.running) begin
      foreach (n.w[k]) n.w[k] = galoisStep(n.w[k]);
      n.acks++;
      if (interval > 0 && n.acks == interval) n.running = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [95:0] modelRng(input model_t m);
    return m.running ? {m.w[2], m.w[1], m.w[0]} : 96'h0;
  endfunction

  function automatic bit modelReq(input model_t m);
    return !m.running && !m.loading;
  endfunction

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check every output of one instance against its model.
  task automatic checkDut(input string tag, input logic v, input logic [95:0] r, input logic q,
                          input logic rdy, input model_t m);
    checkOutput({tag, " rng_valid"},  96'(v),   96'(m.running));
    checkOutput({tag, " rng"},        r,        modelRng(m));
    checkOutput({tag, " reseed_req"}, 96'(q),   96'(modelReq(m)));
    checkOutput({tag, " seed_ready"}, 96'(rdy), 96'(1'b1));
  endtask

  // Drive one cycle of inputs, clock both DUTs and the models, then settle.
  task automatic applyStimulus(input bit sv, input logic [31:0] sd, input bit ack);
    seedValid = sv;
    seedData  = sd;
    rngAck    = ack;
    @(posedge g_clk);
    mA = modelEdge(mA, sv, sd, ack, 0);
    mB = modelEdge(mB, sv, sd, ack, 4);
    #1;
  endtask

  // Assert reset asynchronously, check the reset state, release on a falling edge.
  task automatic resetDuts(input string tag);
    seedValid = 1'b0;
    seedData  = 32'h0;
    rngAck    = 1'b0;
    g_resetn  = 1'b0;
    mA = modelReset();
    mB = modelReset();
    #1;
    checkOutput({tag, " A rng_valid"},  96'(busA.rng_valid),  96'h0);
    checkOutput({tag, " A rng"},        busA.rng,             96'h0);
    checkOutput({tag, " A reseed_req"}, 96'(busA.reseed_req), 96'h1);
    checkOutput({tag, " A seed_ready"}, 96'(busA.seed_ready), 96'h1);
    checkOutput({tag, " B reseed_req"}, 96'(busB.reseed_req), 96'h1);
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Fixed vectors applied to dutA straight out of reset.
    vecs[0]  = '{1'b1, 32'h1, 1'b0, 1'b0, 96'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h2, 1'b0, 1'b0, 96'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h3, 1'b0, 1'b1, {32'h3, 32'h2, 32'h1}, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, {32'h80200002, 32'h1, 32'h80200003}, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, {32'h80200002, 32'h1, 32'h80200003}, 1'b0};
    vecs[5]  = '{1'b1, 32'h0, 1'b0, 1'b0, 96'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h5, 1'b0, 1'b0, 96'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0, 1'b0, 1'b1, {32'h1, 32'h5, 32'h1}, 1'b0};
    vecs[8]  = '{1'b1, 32'h7, 1'b1, 1'b0, 96'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 96'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h9, 1'b0, 1'b0, 96'h0, 1'b0};
    vecs[11] = '{1'b1, 32'hA, 1'b0, 1'b1, {32'hA, 32'h9, 32'h7}, 1'b0};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b1, {32'h5, 32'h80200007, 32'h80200000}, 1'b0};

    resetDuts("reset");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sd, vecs[i].ack);
      checkOutput($sformatf("vec%0d rng_valid", i),  96'(busA.rng_valid),  96'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d rng", i),        busA.rng,             vecs[i].expRng);
      checkOutput($sformatf("vec%0d reseed_req", i), 96'(busA.reseed_req), 96'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d seed_ready", i), 96'(busA.seed_ready), 96'h1);
    end

    // Exhaustion on dutB after four acks; dutA keeps running.
    resetDuts("exh reset");
    applyStimulus(1'b1, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h3, 1'b0);
    for (int a = 1; a <= 3; a++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("exh ack%0d B rng_valid", a), 96'(busB.rng_valid), 96'h1);
      checkDut($sformatf("exh ack%0d B", a), busB.rng_valid, busB.rng, busB.reseed_req,
               busB.seed_ready, mB);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("exh ack4 B rng_valid",  96'(busB.rng_valid),  96'h0);
    checkOutput("exh ack4 B reseed_req", 96'(busB.reseed_req), 96'h1);
    checkOutput("exh ack4 B rng",        busB.rng,             96'h0);
    checkOutput("exh ack4 A rng_valid",  96'(busA.rng_valid),  96'h1);
    checkDut("exh ack4 A", busA.rng_valid, busA.rng, busA.reseed_req, busA.seed_ready, mA);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("exh ack5 B rng_valid",  96'(busB.rng_valid),  96'h0);
    checkOutput("exh ack5 B reseed_req", 96'(busB.reseed_req), 96'h1);
    applyStimulus(1'b1, 32'h4, 1'b0);
    checkOutput("exh beat1 B reseed_req", 96'(busB.reseed_req), 96'h0);
    applyStimulus(1'b1, 32'h5, 1'b0);
    applyStimulus(1'b1, 32'h6, 1'b0);
    checkOutput("exh reseed B rng_valid", 96'(busB.rng_valid), 96'h1);
    checkOutput("exh reseed B rng",       busB.rng,            {32'h6, 32'h5, 32'h4});

    // Reset landing after two of three seed words.
    resetDuts("midload reset");
    applyStimulus(1'b1, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0);
    resetDuts("midload abort");
    applyStimulus(1'b1, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h3, 1'b0);
    checkOutput("midload reseed rng", busA.rng, {32'h3, 32'h2, 32'h1});
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("midload step rng", busA.rng, {32'h80200002, 32'h1, 32'h80200003});

    // Random traffic scored against the models, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) resetDuts("rand reset");
      applyStimulus($urandom_range(0, 7) == 0,
                    ($urandom_range(0, 9) == 0) ? 32'h0 : 32'($urandom()),
                    $urandom_range(0, 1) == 1);
      checkDut("rand A", busA.rng_valid, busA.rng, busA.reseed_req, busA.seed_ready, mA);
      checkDut("rand B", busB.rng_valid, busB.rng, busB.reseed_req, busB.seed_ready, mB);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
